// File: rtl/writeback_stage.sv
// Y86-64 writeback stage: 15x64 register file, sticky status capture and a
// saturating retired-instruction counter.
module writeback_stage #(
  parameter logic [2:0] SAOK  = 3'd1,
  parameter logic [2:0] SHLT  = 3'd2,
  parameter logic [2:0] SADR  = 3'd3,
  parameter logic [2:0] SINS  = 3'd4,
  parameter logic [2:0] SBUB  = 3'd0,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  W_stat,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  output logic [63:0] d_rvalA,
  output logic [63:0] d_rvalB,
  output logic [2:0]  Stat,
  output logic        halted,
  output logic [31:0] retired
);

  localparam logic [3:0] INop = 4'h1;

  logic [63:0] r_regs [0:14];
  logic        r_halted;
  logic [2:0]  r_stat_q;
  logic [31:0] r_retired;

  logic w_commit;
  logic w_halt_cap;
  logic w_wr_e;
  logic w_wr_m;
  logic w_count;

  // Halting instructions never commit, so writes and counting are naturally
  // suppressed in the capture cycle.
  assign w_commit   = (W_stat == SAOK) && !r_halted;
  assign w_halt_cap = !r_halted && (W_stat != SAOK) && (W_stat != SBUB);
  assign w_wr_m     = w_commit && (W_dstM != RNONE);
  assign w_wr_e     = w_commit && (W_dstE != RNONE) && (W_dstE != W_dstM);
  assign w_count    = w_commit && (W_icode != INop) && (r_retired != 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= 64'd0;
      end
    end else begin
      if (w_wr_e) r_regs[W_dstE] <= W_valE;
      if (w_wr_m) r_regs[W_dstM] <= W_valM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted  <= 1'b0;
      r_stat_q  <= SAOK;
      r_retired <= 32'd0;
    end else begin
      if (w_halt_cap) begin
        r_halted <= 1'b1;
        r_stat_q <= W_stat;
      end
      if (w_count) r_retired <= r_retired + 32'd1;
    end
  end

  // No write-through: decode forwards from W itself.
  always_comb begin
    d_rvalA = 64'd0;
    d_rvalB = 64'd0;
    if (d_srcA != RNONE) d_rvalA = r_regs[d_srcA];
    if (d_srcB != RNONE) d_rvalB = r_regs[d_srcB];
  end

  always_comb begin
    if (r_halted)            Stat = r_stat_q;
    else if (W_stat == SBUB) Stat = SAOK;
    else                     Stat = W_stat;
  end

  assign halted  = r_halted;
  assign retired = r_retired;

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL have these parameters: SAOK = 3'd1 (normal status); SHLT = 3'd2 (halt); SADR = 3'd3 (bad address); SINS = 3'd4 (illegal instruction); SBUB = 3'd0 (bubble); RNONE = 4'hF (no register).
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 W_stat  input  3  status of the instruction held in the W pipeline register.
REQ-005 W_icode  input  4  instruction code from W.
REQ-006 W_valE  input  64  ALU result from W.
REQ-007 W_valM  input  64  memory read data from W.
REQ-008 W_dstE  input  4  destination register for valE; RNONE = none.
REQ-009 W_dstM  input  4  destination register for valM; RNONE = none.
REQ-010 d_srcA  input  4  decode read address A.
REQ-011 d_srcB  input  4  decode read address B.
REQ-012 d_rvalA  output  64  register file read data for srcA.
REQ-013 d_rvalB  output  64  register file read data for srcB.
REQ-014 Stat  output  3  processor status.
REQ-015 halted  output  1  sticky stop flag.
REQ-016 retired  output  32  count of retired instructions.

Function
REQ-017 The register file SHALL hold 15 registers of 64 bits each, with IDs 0-14.
REQ-018 The block SHALL treat a W instruction as committing when W_stat == SAOK and halted == 0.
REQ-019 On a committing cycle with W_dstE != RNONE, the block SHALL write W_valE to reg[W_dstE] at the clock edge.
REQ-020 On a committing cycle with W_dstM != RNONE, the block SHALL write W_valM to reg[W_dstM] at the clock edge.
REQ-021 When W_dstE == W_dstM != RNONE, the block SHALL write only W_valM (valM wins, as for popq %rsp).
REQ-022 Non-committing cycles SHALL cause no register writes: bubble, SHLT, SADR, SINS, any other code, or halted == 1.
REQ-023 Reads SHALL be combinational from the current register contents, with no write-through bypass; a write at edge N becomes visible only after edge N. Forwarding is decode's responsibility.
REQ-024 A read of RNONE SHALL return 64'd0.
REQ-025 Status sticky capture: when halted == 0 and W_stat is neither SAOK nor SBUB, the block SHALL set halted to 1 and latch W_stat into stat_q at the edge.
REQ-026 Status capture SHALL include out-of-range W_stat values 5-7, which are latched verbatim.
REQ-027 Once halted == 1, the block SHALL ignore all W inputs until reset.
REQ-028 Stat SHALL equal stat_q when halted == 1.
REQ-029 When halted == 0, Stat SHALL equal SAOK if W_stat == SBUB, and W_stat otherwise; this path is combinational.
REQ-030 The retired counter SHALL increment by 1 on each committing cycle with W_icode != 4'h1 (nop).
REQ-031 The retired counter SHALL saturate at 32'hFFFFFFFF.
REQ-032 Instructions ending in SHLT, SADR or SINS SHALL NOT be counted.
REQ-033 Simultaneous events: in the cycle that sets halted, that instruction SHALL perform no writes and SHALL NOT be counted.

Reset
REQ-034 When rst == 1 at an edge, the block SHALL clear all 15 registers to 0, halted to 0, stat_q to SAOK and retired to 0.
REQ-035 Reset SHALL take priority over any simultaneous write, count or halt capture.
REQ-036 Reset applied mid-operation, including while halted, SHALL fully restore the reset state.
REQ-037 After reset deasserts, the first edge SHALL process W normally.
REQ-038 During reset, d_rvalA, d_rvalB and Stat SHALL follow the combinational rules applied to the cleared state.

Verification
REQ-039 Basic write: stat=SAOK, icode=3, dstE=0, valE=0x1122334455667788, dstM=F; after one edge srcA=0 -> d_rvalA=0x1122334455667788, retired=1.
REQ-040 Write collision: stat=SAOK, dstE=dstM=4, valE=0x10, valM=0x20; after the edge srcB=4 -> d_rvalB=0x20.
REQ-041 Bubble and nop: stat=SBUB, dstE=2, valE=5 -> Stat=SAOK, reg2 unchanged, retired unchanged; then stat=SAOK, icode=1 -> retired unchanged.
REQ-042 Halt freeze: stat=SHLT, dstE=3 -> halted=1, Stat=SHLT, reg3 unchanged; the next cycle stat=SAOK, dstE=3, valE=9 -> reg3 unchanged, Stat stays SHLT.
REQ-043 Reset recovery: while halted with reg3 nonzero, assert rst together with stat=SAOK, dstE=3 -> reg3=0, halted=0, Stat=SAOK, retired=0; read of srcA=F -> 0.
REQ-044 Saturation: force retired to 0xFFFFFFFE, then run two committing non-nop instructions -> retired=0xFFFFFFFF and holds.
